sys_resp_framer: RTL



---
 rtl/sys_pkg.sv | 19 +
 rtl/sys_resp_framer.sv | 88 ++++++++
 2 files changed

// File: rtl/sys_pkg.sv
// Shared encodings for the system controller's TX-side blocks.
package sys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    B0   = 2'd2,
    B1   = 2'd3
  } state_t;

  typedef enum logic {
    REG = 1'b0,
    ALU = 1'b1
  } frame_t;

  localparam logic [7:0] HDR_REG = 8'hA5;
  localparam logic [7:0] HDR_ALU = 8'h5A;

endpackage

// File: rtl/sys_resp_framer.sv
// Frames register-file and ALU responses into bytes for the TX FIFO,
// stalling on FIFO_Full and flagging responses that arrive mid-frame.
module sys_resp_framer
  import sys_pkg::*;
#(
  parameter int width  = 8,
  parameter bit HDR_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [width-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic [2*width-1:0] ALU_OUT,
  input  logic               ALU_Valid,
  input  logic               FIFO_Full,
  output logic [width-1:0]   FIFO_WrData,
  output logic               FIFO_WrEN,
  output logic               Ready,
  output logic               Overrun,
  input  logic               Overrun_clr
);

  state_t             state_q, state_d;
  frame_t             type_q;
  logic [2*width-1:0] hold_q;
  logic               any_vld;
  logic               ovr_set;

  function automatic logic [width-1:0] hdr_byte(input frame_t t);
    return (t == ALU) ? width'(HDR_ALU) : width'(HDR_REG);
  endfunction

  assign any_vld = RdData_Valid | ALU_Valid;
  // Both strobes in IDLE: ALU is taken, the register read is lost.
  assign ovr_set = (state_q == IDLE) ? (RdData_Valid & ALU_Valid) : any_vld;

  always_comb begin
    state_d     = state_q;
    FIFO_WrEN   = 1'b0;
    FIFO_WrData = '0;
    Ready       = 1'b0;
    case (state_q)
      IDLE: begin
        Ready = 1'b1;
        if (any_vld) state_d = HDR_EN ? HDR : B0;
      end
      HDR: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = hdr_byte(type_q);
        if (FIFO_WrEN) state_d = B0;
      end
      B0: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = hold_q[width-1:0];
        if (FIFO_WrEN) state_d = (type_q == ALU) ? B1 : IDLE;
      end
      B1: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = hold_q[2*width-1:width];
        if (FIFO_WrEN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      type_q  <= REG;
      hold_q  <= '0;
      Overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (ALU_Valid) begin
          hold_q <= ALU_OUT;
          type_q <= ALU;
        end else if (RdData_Valid) begin
          hold_q <= {{width{1'b0}}, RdData};
          type_q <= REG;
        end
      end
      if (ovr_set)          Overrun <= 1'b1;
      else if (Overrun_clr) Overrun <= 1'b0;
    end
  end

endmodule
